// File: rtl/change_monitor_pkg.sv
// Shared constants, record layout and a record-field helper for the change monitor.
// The helpers are valid for the default widths; the top is parameterised on its own.
package change_monitor_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_TS_W   = 16;
  localparam int DEF_DEPTH  = 8;

  localparam int REC_W  = DEF_TS_W + DEF_DATA_W;
  localparam int TS_LSB = DEF_DATA_W;

  typedef struct packed {
    logic [DEF_TS_W-1:0]   ts;
    logic [DEF_DATA_W-1:0] value;
  } rec_t;

  function automatic rec_t unpack_rec(input logic [REC_W-1:0] rec);
    rec_t r;
    r.ts    = rec[REC_W-1:TS_LSB];
    r.value = rec[TS_LSB-1:0];
    return r;
  endfunction

endpackage

// File: rtl/mon_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is
// accepted when a pop happens on the same edge.
module mon_sync_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic do_push;
  logic do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // NOTE: every signal assigned in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/change_monitor_ctrl.sv
// Value-change monitor: logs timestamped changes of an observed bus into a
// FWFT record FIFO while the capture window is open.
module change_monitor_ctrl
  import change_monitor_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int TS_W   = DEF_TS_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mon_on,
  input  logic                       mon_off,
  input  logic [DATA_W-1:0]          sample_in,
  output logic                       rec_valid,
  input  logic                       rec_ready,
  output logic [TS_W+DATA_W-1:0]     rec_data,
  output logic                       active,
  output logic                       overflow,
  input  logic                       clr_ovf,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int RW = TS_W + DATA_W;

  logic [TS_W-1:0]   ts_q, ts_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              active_q, active_d;
  logic              arm_q, arm_d;
  logic              overflow_q, overflow_d;

  logic              change_event;
  logic              pop_req;
  logic              fifo_full;
  logic              fifo_empty;
  logic              drop;
  logic [RW-1:0]     push_rec;

  // Evaluated with the pre-edge window, so a change on the mon_off edge is still logged.
  assign change_event = active_q & (arm_q | (sample_in != sample_q));
  assign pop_req      = ~fifo_empty & rec_ready;
  assign drop         = change_event & fifo_full & ~pop_req;
  assign push_rec     = {ts_q, sample_in};

  always_comb begin
    ts_d       = ts_q + TS_W'(1);
    sample_d   = sample_in;
    active_d   = active_q;
    overflow_d = overflow_q;
    if (mon_off)     active_d = 1'b0;
    else if (mon_on) active_d = 1'b1;
    // Arm lasts exactly one cycle after the window opens, forcing a snapshot record.
    arm_d = active_d & ~active_q;
    if (drop)         overflow_d = 1'b1;
    else if (clr_ovf) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q       <= '0;
      sample_q   <= '0;
      active_q   <= 1'b0;
      arm_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      ts_q       <= ts_d;
      sample_q   <= sample_d;
      active_q   <= active_d;
      arm_q      <= arm_d;
      overflow_q <= overflow_d;
    end
  end

  mon_sync_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (change_event),
    .pop     (rec_ready),
    .wr_data (push_rec),
    .rd_data (rec_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

  assign rec_valid = ~fifo_empty;
  assign active    = active_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_change_monitor_ctrl.sv
// Bench for change_monitor_ctrl: queue-based record model checked every cycle,
// plus hand-computed expectations along the directed scenarios.
module tb_change_monitor_ctrl;
  import change_monitor_pkg::*;

  localparam int DATA_W = 4;
  localparam int TS_W   = 16;
  localparam int DEPTH  = 8;
  localparam int RW     = TS_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mon_on = 1'b0;
  logic              mon_off = 1'b0;
  logic [DATA_W-1:0] sample_in = '0;
  logic              rec_ready = 1'b0;
  logic              clr_ovf = 1'b0;
  logic              rec_valid;
  logic [RW-1:0]     rec_data;
  logic              active;
  logic              overflow;
  logic [3:0]        count;

  int total = 0;
  int bad   = 0;

  change_monitor_ctrl #(
    .DATA_W (DATA_W),
    .TS_W   (TS_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mon_on    (mon_on),
    .mon_off   (mon_off),
    .sample_in (sample_in),
    .rec_valid (rec_valid),
    .rec_ready (rec_ready),
    .rec_data  (rec_data),
    .active    (active),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the window, the "first cycle after enable" snapshot and a record queue.
  logic [RW-1:0] m_q[$];
  int unsigned   m_ts = 0;
  bit            m_active = 0;
  bit            m_first = 0;
  bit            m_ovf = 0;
  logic [3:0]    m_prev = '0;

  always @(posedge clk or posedge rst) begin
    bit ev, pop, drop, nxt;
    int n;
    if (rst) begin
      m_q.delete();
      m_ts = 0; m_active = 0; m_first = 0; m_ovf = 0; m_prev = '0;
    end else begin
      n    = m_q.size();
      ev   = m_active && (m_first || sample_in != m_prev);
      pop  = rec_ready && n > 0;
      drop = ev && n == DEPTH && !pop;
      if (pop) void'(m_q.pop_front());
      if (ev && !drop) m_q.push_back({m_ts[15:0], sample_in});
      m_ovf    = drop ? 1'b1 : (clr_ovf ? 1'b0 : m_ovf);
      nxt      = mon_off ? 1'b0 : (mon_on ? 1'b1 : m_active);
      m_first  = nxt && !m_active;
      m_active = nxt;
      m_prev   = sample_in;
      m_ts     = (m_ts + 1) % 65536;
    end
  end

  always @(negedge clk) begin
    check("active", active, m_active);
    check("overflow", overflow, m_ovf);
    check("count", count, m_q.size());
    check("rec_valid", rec_valid, m_q.size() != 0);
    if (m_q.size() != 0) check("rec_data", rec_data, m_q[0]);
  end

  // Advance to the negedge inside the cycle whose timestamp register equals n.
  task automatic wait_ts(input int n);
    int guard = 0;
    @(negedge clk);
    while (m_ts != n && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (m_ts != n) begin
      total++;
      bad++;
      $display("FAIL wait_ts: ts=%0d target=%0d", m_ts, n);
    end
  endtask

  rec_t r;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_count", count, 0);
    check("rst_valid", rec_valid, 0);
    check("rst_active", active, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0;

    // 1: enable with a static bus -> single snapshot record {3,0}
    wait_ts(2);  mon_on = 1'b1;
    wait_ts(3);  mon_on = 1'b0;
    wait_ts(8);
    check("t1_count", count, 1);
    check("t1_data", rec_data, 20'h00030);
    check("t1_active", active, 1);
    rec_ready = 1'b1;
    wait_ts(9);  rec_ready = 1'b0;
    check("t1_drained", count, 0);

    // 2: three changes, each visible one cycle later
    rec_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      wait_ts(10 * k);     sample_in = 4'(k);
      wait_ts(10 * k + 1);
      check("t2_valid", rec_valid, 1);
      check("t2_data", rec_data, {16'(10 * k), 4'(k)});
    end

    // 3: changes while off are not logged; re-enable gives snapshot {61,3}
    wait_ts(40); mon_off = 1'b1;
    wait_ts(41); mon_off = 1'b0;
    check("t3_off", active, 0);
    wait_ts(45); sample_in = 4'd0;
    wait_ts(50); sample_in = 4'd2;
    wait_ts(59); check("t3_none", count, 0);
    wait_ts(60); sample_in = 4'd3; mon_on = 1'b1;
    wait_ts(61); mon_on = 1'b0;
    wait_ts(62);
    check("t3_valid", rec_valid, 1);
    r = unpack_rec(rec_data);
    check("t3_ts", r.ts, 61);
    check("t3_val", r.value, 3);
    wait_ts(65); rec_ready = 1'b0;
    check("t3_empty", count, 0);

    // 4: ten changes into an undrained FIFO -> 8 kept, overflow sticky
    wait_ts(70);
    for (int i = 0; i < 10; i++) begin
      sample_in = 4'(4 + i);
      wait_ts(71 + i);
    end
    wait_ts(81);
    check("t4_count", count, 8);
    check("t4_ovf", overflow, 1);
    check("t4_head", rec_data, 20'h00464);
    wait_ts(82); clr_ovf = 1'b1;
    wait_ts(83); clr_ovf = 1'b0;
    check("t4_clr", overflow, 0);
    wait_ts(85); rec_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t4_drain", rec_data, {16'(70 + i), 4'(4 + i)});
      wait_ts(86 + i);
    end
    rec_ready = 1'b0;
    check("t4_empty", count, 0);

    // 5: full FIFO, change coincident with pop; then on+off together
    wait_ts(100);
    for (int i = 0; i < 8; i++) begin
      sample_in = 4'(i);
      wait_ts(101 + i);
    end
    check("t5_full", count, 8);
    wait_ts(110); sample_in = 4'd8; rec_ready = 1'b1;
    wait_ts(111); rec_ready = 1'b0;
    check("t5_count", count, 8);
    check("t5_ovf", overflow, 0);
    check("t5_head", rec_data, 20'h00651);
    wait_ts(112); mon_on = 1'b1; mon_off = 1'b1;
    wait_ts(113); mon_on = 1'b0; mon_off = 1'b0;
    check("t5_onoff", active, 0);

    // 6: async reset with 5 records held and the window open
    wait_ts(115); rec_ready = 1'b1;
    wait_ts(119); rec_ready = 1'b0;
    wait_ts(120); mon_on = 1'b1;
    wait_ts(121); mon_on = 1'b0;
    wait_ts(123);
    check("t6_pre_count", count, 5);
    check("t6_pre_active", active, 1);
    #3 rst = 1'b1;
    #1;
    check("t6_count", count, 0);
    check("t6_valid", rec_valid, 0);
    check("t6_active", active, 0);
    check("t6_ovf", overflow, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mon_on = 1'b1;
    wait_ts(1); mon_on = 1'b0;
    wait_ts(2);
    check("t6_restart", rec_data, 20'h00018);
    check("t6_restart_cnt", count, 1);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
